// File: rtl/fifo_rd_ctrl_if.sv
// rtl/fifo_rd_ctrl_if.sv - read-side FIFO controller bus: memory port, sync pointers, status, output stage
interface fifo_rd_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [DATASIZE-1:0] rdata;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   rlevel;
  logic [DATASIZE-1:0] rdata_q;
  logic                rvalid;
  logic                runderflow;

  modport master (
    input  rinc, rq2_wptr, rdata,
    output raddr, rptr, rempty, ralmost_empty, rlevel, rdata_q, rvalid, runderflow
  );

  modport slave (
    output rinc, rq2_wptr, rdata,
    input  raddr, rptr, rempty, ralmost_empty, rlevel, rdata_q, rvalid, runderflow
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side controller: Gray read pointer, empty/level status, registered output
module fifo_rd_ctrl #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 1
) (
  input  logic          rclk,
  input  logic          rrst_n,
  fifo_rd_ctrl_if.master bus
);
  localparam logic [ADDRSIZE:0] AE_LIMIT = (ADDRSIZE+1)'(AE_THRESH);

  logic [ADDRSIZE:0]   rbin;
  logic [ADDRSIZE:0]   rbinnext;
  logic [ADDRSIZE:0]   rgraynext;
  logic [ADDRSIZE:0]   wbin;
  logic [ADDRSIZE:0]   level_next;
  logic                rd_en;

  logic [ADDRSIZE:0]   rptr_q;
  logic                rempty_q;
  logic                ralmost_empty_q;
  logic [ADDRSIZE:0]   rlevel_q;
  logic [DATASIZE-1:0] rdata_q_q;
  logic                rvalid_q;
  logic                runderflow_q;

  always_comb begin
    rd_en     = bus.rinc & ~rempty_q;
    rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    rgraynext = (rbinnext >> 1) ^ rbinnext;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(bus.rq2_wptr >> i);
    end
    level_next = wbin - rbinnext;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin            <= '0;
      rptr_q          <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rlevel_q        <= '0;
      rdata_q_q       <= '0;
      rvalid_q        <= 1'b0;
      runderflow_q    <= 1'b0;
    end else begin
      rbin            <= rbinnext;
      rptr_q          <= rgraynext;
      rempty_q        <= (rgraynext == bus.rq2_wptr);
      rlevel_q        <= level_next;
      ralmost_empty_q <= (level_next <= AE_LIMIT);
      rvalid_q        <= rd_en;
      if (rd_en) begin
        rdata_q_q <= bus.rdata;
      end
      if (bus.rinc && rempty_q) begin
        runderflow_q <= 1'b1;
      end
    end
  end

  assign bus.raddr         = rbin[ADDRSIZE-1:0];
  assign bus.rptr          = rptr_q;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = ralmost_empty_q;
  assign bus.rlevel        = rlevel_q;
  assign bus.rdata_q       = rdata_q_q;
  assign bus.rvalid        = rvalid_q;
  assign bus.runderflow    = runderflow_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;
  logic rclk   = 1'b0;
  logic rrst_n = 1'b1;
  logic clk_on = 1'b0;

  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl_if #(.DATASIZE(8), .ADDRSIZE(4)) bus ();

  fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .AE_THRESH(1)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  assign bus.rdata = mem[bus.raddr];

  always #5 if (clk_on) rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rempty"},     32'(bus.rempty), 1);
    check({pfx, "_almost"},     32'(bus.ralmost_empty), 1);
    check({pfx, "_rptr"},       32'(bus.rptr), 0);
    check({pfx, "_raddr"},      32'(bus.raddr), 0);
    check({pfx, "_rlevel"},     32'(bus.rlevel), 0);
    check({pfx, "_rvalid"},     32'(bus.rvalid), 0);
    check({pfx, "_runderflow"}, 32'(bus.runderflow), 0);
    check({pfx, "_rdata_q"},    32'(bus.rdata_q), 0);
  endtask

  task automatic pulse_reset();
    rrst_n = 1'b0;
    #1;
    rrst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_word [3];
    logic [4:0] prev_rptr;
    int wtot, rx, d1, d2, written, cyc;
    bit wrap_seen;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bus.rinc     = 1'b0;
    bus.rq2_wptr = 5'b00000;

    // 1: asynchronous reset with the clock stopped
    #2 rrst_n = 1'b0;
    #1 check_reset_values("t1");
    rrst_n = 1'b1;
    #2 clk_on = 1'b1;

    // 2: three words available, drain them back to back
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
    exp_word[0] = 8'hA1; exp_word[1] = 8'hB2; exp_word[2] = 8'hC3;
    bus.rq2_wptr = 5'b00010;
    tick();
    check("t2_rempty_after_wr", 32'(bus.rempty), 0);
    check("t2_rlevel_after_wr", 32'(bus.rlevel), 3);
    check("t2_almost_after_wr", 32'(bus.ralmost_empty), 0);
    bus.rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_raddr%0d", i), 32'(bus.raddr), 32'(i));
      tick();
      check($sformatf("t2_rvalid%0d", i), 32'(bus.rvalid), 1);
      check($sformatf("t2_rdata%0d", i), 32'(bus.rdata_q), 32'(exp_word[i]));
      check($sformatf("t2_rlevel%0d", i), 32'(bus.rlevel), 32'(2 - i));
      check($sformatf("t2_rempty%0d", i), 32'(bus.rempty), (i == 2) ? 1 : 0);
    end
    check("t2_rptr_end", 32'(bus.rptr), 32'h02);
    check("t2_almost_end", 32'(bus.ralmost_empty), 1);

    // 3: read while empty is ignored and sticks in runderflow
    check("t3_underflow_pre", 32'(bus.runderflow), 0);
    tick();
    check("t3_rptr", 32'(bus.rptr), 32'h02);
    check("t3_rvalid", 32'(bus.rvalid), 0);
    check("t3_rdata_hold", 32'(bus.rdata_q), 32'hC3);
    check("t3_underflow", 32'(bus.runderflow), 1);
    bus.rinc = 1'b0;
    tick(); tick();
    check("t3_underflow_sticky", 32'(bus.runderflow), 1);
    check("t3_raddr", 32'(bus.raddr), 3);

    // 4: streaming with a two-cycle delayed writer pointer, crossing the pointer wrap
    wtot = 3; d1 = 3; d2 = 3; rx = 0; written = 0; wrap_seen = 0;
    prev_rptr = bus.rptr;
    cyc = 0;
    while ((rx < 40 || !bus.rempty) && cyc < 2000) begin
      tick();
      cyc++;
      if (bus.rvalid) begin
        check($sformatf("t4_word%0d", rx), 32'(bus.rdata_q), 32'((rx * 7 + 3) & 8'hFF));
        rx++;
      end
      if (bus.rptr != prev_rptr) begin
        check("t4_gray_step", 32'($countones(bus.rptr ^ prev_rptr)), 1);
        if (prev_rptr == 5'b10000 && bus.rptr == 5'b00000) wrap_seen = 1;
        prev_rptr = bus.rptr;
      end
      if (written < 40 && (wtot - (3 + rx)) < 16) begin
        mem[wtot % 16] = 8'((written * 7 + 3) & 8'hFF);
        wtot++;
        written++;
      end
      bus.rq2_wptr = gray(d2[4:0]);
      d2 = d1;
      d1 = wtot;
      bus.rinc = (rx < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check("t4_timeout", 32'(cyc < 2000), 1);
    check("t4_count", 32'(rx), 40);
    check("t4_wrap_seen", 32'(wrap_seen), 1);
    check("t4_rempty_end", 32'(bus.rempty), 1);
    check("t4_rptr_end", 32'(bus.rptr), 32'(gray(5'd11)));

    // 5: full FIFO level and almost-empty threshold
    bus.rinc = 1'b0;
    pulse_reset();
    bus.rq2_wptr = 5'b11000;
    tick();
    check("t5_rlevel_full", 32'(bus.rlevel), 16);
    check("t5_almost_full", 32'(bus.ralmost_empty), 0);
    check("t5_rempty_full", 32'(bus.rempty), 0);
    bus.rinc = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("t5_rlevel_2", 32'(bus.rlevel), 2);
    check("t5_almost_2", 32'(bus.ralmost_empty), 0);
    tick();
    bus.rinc = 1'b0;
    check("t5_rlevel_1", 32'(bus.rlevel), 1);
    check("t5_almost_1", 32'(bus.ralmost_empty), 1);
    check("t5_rempty_1", 32'(bus.rempty), 0);

    // 6: reset asserted mid-burst, 2 ns after an edge
    pulse_reset();
    bus.rq2_wptr = gray(5'd5);
    mem[0] = 8'h5A; mem[1] = 8'h6B; mem[2] = 8'h7C;
    tick();
    bus.rinc = 1'b1;
    tick(); tick();
    check("t6_rvalid_pre", 32'(bus.rvalid), 1);
    check("t6_raddr_pre", 32'(bus.raddr), 2);
    #1 rrst_n = 1'b0;
    #1 check_reset_values("t6");
    bus.rinc = 1'b0;
    #1 rrst_n = 1'b1;
    tick();
    check("t6_rempty_rel", 32'(bus.rempty), 0);
    check("t6_rlevel_rel", 32'(bus.rlevel), 5);
    check("t6_raddr_rel", 32'(bus.raddr), 0);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    check("t6_first_rvalid", 32'(bus.rvalid), 1);
    check("t6_first_rdata", 32'(bus.rdata_q), 32'h5A);
    check("t6_raddr_next", 32'(bus.raddr), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
